// File: rtl/ps2_kbd_decoder_if.sv
// Keyboard decoder bus: receive-stage byte strobe in, LC-3 KBSR/KBDR view out.
interface ps2_kbd_decoder_if #(
   parameter int ERR_W = 8
);
   logic             ps2_rdy;
   logic [7:0]       ps2_byte;
   logic             ps2_err;
   logic             kbd_rd;
   logic             kbsr_rdy;
   logic [7:0]       kbdr;
   logic             kbd_ovf;
   logic [ERR_W-1:0] err_cnt;

   modport master (
      output ps2_rdy, ps2_byte, ps2_err, kbd_rd,
      input  kbsr_rdy, kbdr, kbd_ovf, err_cnt
   );

   modport slave (
      input  ps2_rdy, ps2_byte, ps2_err, kbd_rd,
      output kbsr_rdy, kbdr, kbd_ovf, err_cnt
   );
endinterface

// File: rtl/ps2_kbd_decoder.sv
// PS/2 set-2 scan-code decoder: E0/F0 prefix tracking, Shift/Caps state,
// ASCII translation and a character FIFO exposed as LC-3 KBSR/KBDR.
module ps2_kbd_decoder #(
   parameter int DEPTH = 8,
   parameter int ERR_W = 8
) (
   input logic               clk,
   input logic               rst_n,
   ps2_kbd_decoder_if.slave  bus
);
   localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

   state_t           state_q, state_d;
   logic             is_make, is_brk, is_ext;
   logic             shift_l, shift_r, caps, caps_held, shift;
   logic [7:0]       lo_c, hi_c, ch;
   logic             hit, alpha, use_hi, push_req;
   logic [ERR_W-1:0] err_q;

   logic [7:0]       mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             empty, full, push, pop, ovf_q;

   // ---------------- prefix FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      is_make = 1'b0;
      is_brk  = 1'b0;
      is_ext  = 1'b0;
      if (bus.ps2_rdy) begin
         if (bus.ps2_err) begin
            state_d = IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  if (bus.ps2_byte == 8'hE0)      state_d = EXT;
                  else if (bus.ps2_byte == 8'hF0) state_d = BRK;
                  else                            is_make = 1'b1;
               end
               EXT: begin
                  if (bus.ps2_byte == 8'hF0) begin
                     state_d = EXT_BRK;
                  end else begin
                     is_make = 1'b1;
                     is_ext  = 1'b1;
                     state_d = IDLE;
                  end
               end
               BRK: begin
                  is_brk  = 1'b1;
                  state_d = IDLE;
               end
               EXT_BRK: begin
                  is_brk  = 1'b1;
                  is_ext  = 1'b1;
                  state_d = IDLE;
               end
               default: state_d = IDLE;
            endcase
         end
      end
   end

   // ---------------- modifiers ----------------
   // Only non-extended codes touch modifiers, so E0 12 (fake shift) is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_l   <= 1'b0;
         shift_r   <= 1'b0;
         caps      <= 1'b0;
         caps_held <= 1'b0;
      end else if ((is_make || is_brk) && !is_ext) begin
         case (bus.ps2_byte)
            8'h12: shift_l <= is_make;
            8'h59: shift_r <= is_make;
            8'h58: begin
               if (is_make && !caps_held) begin
                  caps      <= ~caps;
                  caps_held <= 1'b1;
               end else if (is_brk) begin
                  caps_held <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign shift = shift_l | shift_r;

   // ---------------- translation ----------------
   always_comb begin
      lo_c  = 8'h00;
      hi_c  = 8'h00;
      hit   = 1'b1;
      alpha = 1'b0;
      case (bus.ps2_byte)
         8'h1C: begin lo_c = 8'h61; alpha = 1'b1; end
         8'h32: begin lo_c = 8'h62; alpha = 1'b1; end
         8'h21: begin lo_c = 8'h63; alpha = 1'b1; end
         8'h23: begin lo_c = 8'h64; alpha = 1'b1; end
         8'h24: begin lo_c = 8'h65; alpha = 1'b1; end
         8'h2B: begin lo_c = 8'h66; alpha = 1'b1; end
         8'h34: begin lo_c = 8'h67; alpha = 1'b1; end
         8'h33: begin lo_c = 8'h68; alpha = 1'b1; end
         8'h43: begin lo_c = 8'h69; alpha = 1'b1; end
         8'h3B: begin lo_c = 8'h6A; alpha = 1'b1; end
         8'h42: begin lo_c = 8'h6B; alpha = 1'b1; end
         8'h4B: begin lo_c = 8'h6C; alpha = 1'b1; end
         8'h3A: begin lo_c = 8'h6D; alpha = 1'b1; end
         8'h31: begin lo_c = 8'h6E; alpha = 1'b1; end
         8'h44: begin lo_c = 8'h6F; alpha = 1'b1; end
         8'h4D: begin lo_c = 8'h70; alpha = 1'b1; end
         8'h15: begin lo_c = 8'h71; alpha = 1'b1; end
         8'h2D: begin lo_c = 8'h72; alpha = 1'b1; end
         8'h1B: begin lo_c = 8'h73; alpha = 1'b1; end
         8'h2C: begin lo_c = 8'h74; alpha = 1'b1; end
         8'h3C: begin lo_c = 8'h75; alpha = 1'b1; end
         8'h2A: begin lo_c = 8'h76; alpha = 1'b1; end
         8'h1D: begin lo_c = 8'h77; alpha = 1'b1; end
         8'h22: begin lo_c = 8'h78; alpha = 1'b1; end
         8'h35: begin lo_c = 8'h79; alpha = 1'b1; end
         8'h1A: begin lo_c = 8'h7A; alpha = 1'b1; end
         8'h16: begin lo_c = 8'h31; hi_c = 8'h21; end
         8'h1E: begin lo_c = 8'h32; hi_c = 8'h40; end
         8'h26: begin lo_c = 8'h33; hi_c = 8'h23; end
         8'h25: begin lo_c = 8'h34; hi_c = 8'h24; end
         8'h2E: begin lo_c = 8'h35; hi_c = 8'h25; end
         8'h36: begin lo_c = 8'h36; hi_c = 8'h5E; end
         8'h3D: begin lo_c = 8'h37; hi_c = 8'h26; end
         8'h3E: begin lo_c = 8'h38; hi_c = 8'h2A; end
         8'h46: begin lo_c = 8'h39; hi_c = 8'h28; end
         8'h45: begin lo_c = 8'h30; hi_c = 8'h29; end
         8'h29: begin lo_c = 8'h20; hi_c = 8'h20; end
         8'h5A: begin lo_c = 8'h0A; hi_c = 8'h0A; end
         8'h66: begin lo_c = 8'h08; hi_c = 8'h08; end
         default: hit = 1'b0;
      endcase
      if (alpha) hi_c = lo_c & 8'hDF;
   end

   assign use_hi = alpha ? (shift ^ caps) : shift;

   always_comb begin
      push_req = 1'b0;
      ch       = use_hi ? hi_c : lo_c;
      if (is_make && !is_ext) begin
         push_req = hit;
      end else if (is_make && is_ext && bus.ps2_byte == 8'h5A) begin
         push_req = 1'b1;
         ch       = 8'h0A;
      end
   end

   // ---------------- error counter ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_q <= '0;
      else if (bus.ps2_rdy && bus.ps2_err && err_q != {ERR_W{1'b1}})
         err_q <= err_q + 1'b1;
   end

   // ---------------- character FIFO ----------------
   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));
   assign pop   = bus.kbd_rd & ~empty;
   // A pop frees the slot for a same-cycle push even when full.
   assign push  = push_req & (~full | pop);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= ch;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         if (push_req && !push) ovf_q <= 1'b1;
      end
   end

   assign bus.kbsr_rdy = ~empty;
   assign bus.kbdr     = empty ? 8'h00 : mem[rd_ptr];
   assign bus.kbd_ovf  = ovf_q;
   assign bus.err_cnt  = err_q;
endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Bench for ps2_kbd_decoder: byte-vector table plus FIFO corner sequences,
// expected characters tracked in a scoreboard queue.
module tb_ps2_kbd_decoder;
   localparam int DEPTH = 8;
   localparam int ERR_W = 8;
   localparam int NV    = 46;

   typedef struct {
      logic [7:0] b;
      logic       e;
      logic       ev;
      logic [7:0] ec;
   } vec_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   logic [7:0] sb[$];
   logic       ovf_exp;
   int         err_exp;
   vec_t       vecs [NV];

   ps2_kbd_decoder_if #(.ERR_W(ERR_W)) bus ();

   ps2_kbd_decoder #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_state();
      check("kbsr_rdy", 32'(bus.kbsr_rdy), 32'(sb.size() != 0));
      check("kbdr", 32'(bus.kbdr), (sb.size() != 0) ? 32'(sb[0]) : 32'h0);
      check("kbd_ovf", 32'(bus.kbd_ovf), 32'(ovf_exp));
      check("err_cnt", 32'(bus.err_cnt), 32'(err_exp));
   endtask

   // One clock: drive inputs, let the edge take them, update the model, compare.
   task automatic step(input logic rdy, input logic [7:0] b, input logic e,
                       input logic rd, input logic ev, input logic [7:0] ec);
      bus.ps2_rdy  = rdy;
      bus.ps2_byte = b;
      bus.ps2_err  = e;
      bus.kbd_rd   = rd;
      @(posedge clk);
      #1;
      bus.ps2_rdy  = 1'b0;
      bus.ps2_err  = 1'b0;
      bus.kbd_rd   = 1'b0;
      if (rd && sb.size() != 0) void'(sb.pop_front());
      if (ev) begin
         if (sb.size() < DEPTH) sb.push_back(ec);
         else                   ovf_exp = 1'b1;
      end
      if (rdy && e && err_exp < 255) err_exp++;
      check_state();
   endtask

   task automatic drain();
      int n;
      n = sb.size();
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
   endtask

   task automatic setv(input int i, input logic [7:0] b, input logic e,
                       input logic ev, input logic [7:0] ec);
      vecs[i].b  = b;
      vecs[i].e  = e;
      vecs[i].ev = ev;
      vecs[i].ec = ec;
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      ovf_exp = 1'b0;
      err_exp = 0;

      setv( 0, 8'h1C, 0, 1, 8'h61); setv( 1, 8'hF0, 0, 0, 8'h00);
      setv( 2, 8'h1C, 0, 0, 8'h00); setv( 3, 8'h12, 0, 0, 8'h00);
      setv( 4, 8'h1C, 0, 1, 8'h41); setv( 5, 8'hF0, 0, 0, 8'h00);
      setv( 6, 8'h1C, 0, 0, 8'h00); setv( 7, 8'hF0, 0, 0, 8'h00);
      setv( 8, 8'h12, 0, 0, 8'h00); setv( 9, 8'h1C, 0, 1, 8'h61);
      setv(10, 8'h58, 0, 0, 8'h00); setv(11, 8'h58, 0, 0, 8'h00);
      setv(12, 8'hF0, 0, 0, 8'h00); setv(13, 8'h58, 0, 0, 8'h00);
      setv(14, 8'h1C, 0, 1, 8'h41); setv(15, 8'h59, 0, 0, 8'h00);
      setv(16, 8'h1C, 0, 1, 8'h61); setv(17, 8'h16, 0, 1, 8'h21);
      setv(18, 8'h45, 0, 1, 8'h29); setv(19, 8'hF0, 0, 0, 8'h00);
      setv(20, 8'h59, 0, 0, 8'h00); setv(21, 8'h16, 0, 1, 8'h31);
      setv(22, 8'h58, 0, 0, 8'h00); setv(23, 8'hF0, 0, 0, 8'h00);
      setv(24, 8'h58, 0, 0, 8'h00); setv(25, 8'hE0, 0, 0, 8'h00);
      setv(26, 8'h5A, 0, 1, 8'h0A); setv(27, 8'hE0, 0, 0, 8'h00);
      setv(28, 8'h75, 0, 0, 8'h00); setv(29, 8'hE0, 0, 0, 8'h00);
      setv(30, 8'hF0, 0, 0, 8'h00); setv(31, 8'h75, 0, 0, 8'h00);
      setv(32, 8'h1C, 0, 1, 8'h61); setv(33, 8'hE0, 1, 0, 8'h00);
      setv(34, 8'h1C, 0, 1, 8'h61); setv(35, 8'h29, 0, 1, 8'h20);
      setv(36, 8'h5A, 0, 1, 8'h0A); setv(37, 8'h66, 0, 1, 8'h08);
      setv(38, 8'h1A, 0, 1, 8'h7A); setv(39, 8'h0E, 0, 0, 8'h00);
      setv(40, 8'hF0, 1, 0, 8'h00); setv(41, 8'h1C, 0, 1, 8'h61);
      setv(42, 8'hE0, 0, 0, 8'h00); setv(43, 8'hF0, 0, 0, 8'h00);
      setv(44, 8'h5A, 0, 0, 8'h00); setv(45, 8'h45, 0, 1, 8'h30);

      rst_n        = 1'b0;
      bus.ps2_rdy  = 1'b0;
      bus.ps2_byte = 8'h00;
      bus.ps2_err  = 1'b0;
      bus.kbd_rd   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_state();
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         step(1'b1, vecs[i].b, vecs[i].e, 1'b0, vecs[i].ev, vecs[i].ec);
         if (sb.size() >= 4) drain();
      end
      drain();

      // pop on empty is ignored; push+pop on empty keeps the push
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b1, 8'h1C, 1'b0, 1'b1, 1'b1, 8'h61);
      drain();

      // fill a..h, i is dropped on full
      step(1'b1, 8'h1C, 0, 0, 1, 8'h61);
      step(1'b1, 8'h32, 0, 0, 1, 8'h62);
      step(1'b1, 8'h21, 0, 0, 1, 8'h63);
      step(1'b1, 8'h23, 0, 0, 1, 8'h64);
      step(1'b1, 8'h24, 0, 0, 1, 8'h65);
      step(1'b1, 8'h2B, 0, 0, 1, 8'h66);
      step(1'b1, 8'h34, 0, 0, 1, 8'h67);
      step(1'b1, 8'h33, 0, 0, 1, 8'h68);
      check("ovf_before_full_push", 32'(bus.kbd_ovf), 32'h0);
      step(1'b1, 8'h43, 0, 0, 1, 8'h69);
      check("ovf_after_drop", 32'(bus.kbd_ovf), 32'h1);
      // push with pop while full: 'a' leaves, 'j' enters
      step(1'b1, 8'h3B, 0, 1, 1, 8'h6A);
      check("sb_depth_full", 32'(sb.size()), 32'(DEPTH));
      drain();

      // saturate the error counter
      for (int i = 0; i < 260; i++) step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 8'h00);
      check("err_cnt_sat", 32'(bus.err_cnt), 32'hFF);
      step(1'b1, 8'h1C, 0, 0, 1, 8'h61);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
